// File: rtl/la_trace_decoder.sv
// Logic-analyzer trace decoder: expands run-length records {repeat_count, signals}
// into per-sample AXI-Stream beats, flagging resync after overflow markers.
module la_trace_decoder #(
   parameter int pDATA_WIDTH = 32,
   parameter int pSIG_WIDTH  = 24,
   parameter int pCNT_WIDTH  = 16
) (
   input  logic                   axis_clk,
   input  logic                   axis_rst_n,
   input  logic                   dec_en,
   input  logic                   s_tvalid,
   output logic                   s_tready,
   input  logic [pDATA_WIDTH-1:0] s_tdata,
   input  logic                   s_tlast,
   input  logic [1:0]             s_tuser,
   output logic                   o_valid,
   input  logic                   o_ready,
   output logic [pSIG_WIDTH-1:0]  o_signal,
   output logic [1:0]             o_user,
   output logic                   o_last,
   output logic                   o_resync,
   output logic [pCNT_WIDTH-1:0]  ovf_count,
   output logic [pCNT_WIDTH-1:0]  rec_count
);

   localparam int RC_WIDTH = pDATA_WIDTH - pSIG_WIDTH;

   localparam logic ST_IDLE   = 1'b0;
   localparam logic ST_EXPAND = 1'b1;

   logic                  state_q,    state_d;
   logic [RC_WIDTH-1:0]   rem_cnt_q,  rem_cnt_d;
   logic [pSIG_WIDTH-1:0] sig_q,      sig_d;
   logic [1:0]            user_q,     user_d;
   logic                  last_q,     last_d;
   logic                  resync_q,   resync_d;
   logic                  ovf_pend_q, ovf_pend_d;
   logic [pCNT_WIDTH-1:0] ovf_cnt_q,  ovf_cnt_d;
   logic [pCNT_WIDTH-1:0] rec_cnt_q,  rec_cnt_d;

   logic [RC_WIDTH-1:0]   rec_rc;
   logic                  final_beat;
   logic                  accept;
   logic                  fire;

   always_comb begin
      rec_rc     = s_tdata[pDATA_WIDTH-1:pSIG_WIDTH];
      final_beat = (state_q == ST_EXPAND) && (rem_cnt_q == RC_WIDTH'(1));
      // The final beat and the next record share a cycle, so the handoff is bubble-free.
      s_tready   = dec_en && ((state_q == ST_IDLE) || (final_beat && o_ready));
      accept     = s_tvalid && s_tready;
      fire       = (state_q == ST_EXPAND) && o_ready;
   end

   always_comb begin
      // NOTE: every _d gets a default first so no path through this block infers a latch.
      state_d    = state_q;
      rem_cnt_d  = rem_cnt_q;
      sig_d      = sig_q;
      user_d     = user_q;
      last_d     = last_q;
      resync_d   = resync_q;
      ovf_pend_d = ovf_pend_q;
      ovf_cnt_d  = ovf_cnt_q;
      rec_cnt_d  = rec_cnt_q;

      if (!dec_en) begin
         state_d    = ST_IDLE;
         rem_cnt_d  = '0;
         resync_d   = 1'b0;
         ovf_pend_d = 1'b0;
      end else begin
         if (fire) begin
            rem_cnt_d = rem_cnt_q - RC_WIDTH'(1);
            resync_d  = 1'b0;
            if (final_beat) state_d = ST_IDLE;
         end
         if (accept) begin
            rec_cnt_d = rec_cnt_q + pCNT_WIDTH'(1);
            if (rec_rc == '0) begin
               // Marker: no sample; its s_tlast is intentionally dropped.
               ovf_pend_d = 1'b1;
               if (ovf_cnt_q != '1) ovf_cnt_d = ovf_cnt_q + pCNT_WIDTH'(1);
            end else begin
               state_d    = ST_EXPAND;
               rem_cnt_d  = rec_rc;
               sig_d      = s_tdata[pSIG_WIDTH-1:0];
               user_d     = s_tuser;
               last_d     = s_tlast;
               resync_d   = ovf_pend_q;
               ovf_pend_d = 1'b0;
            end
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         state_q    <= ST_IDLE;
         rem_cnt_q  <= '0;
         sig_q      <= '0;
         user_q     <= '0;
         last_q     <= 1'b0;
         resync_q   <= 1'b0;
         ovf_pend_q <= 1'b0;
         ovf_cnt_q  <= '0;
         rec_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         rem_cnt_q  <= rem_cnt_d;
         sig_q      <= sig_d;
         user_q     <= user_d;
         last_q     <= last_d;
         resync_q   <= resync_d;
         ovf_pend_q <= ovf_pend_d;
         ovf_cnt_q  <= ovf_cnt_d;
         rec_cnt_q  <= rec_cnt_d;
      end
   end

   assign o_valid   = (state_q == ST_EXPAND);
   assign o_signal  = sig_q;
   assign o_user    = user_q;
   assign o_last    = last_q && final_beat;
   assign o_resync  = resync_q;
   assign ovf_count = ovf_cnt_q;
   assign rec_count = rec_cnt_q;

endmodule
